adc_channel_sequencer: RTL
==========================

// Module: adc_channel_sequencer
// PURPOSE
//  Schedules AD7324 conversions across 4 channels (0=Vout,1=Temp,2=Vin,3=Iout) at a fixed rate.
//  Builds each SPI control word, handshakes with the SPI shift engine and demuxes returned frames
//  into per-channel result registers with update strobes. Sits between the SPI engine and the
//  converter control loop. Vout can be given every other slot for loop bandwidth.
// PARAMETERS
//  PERIOD       200      clk cycles between frame starts (>= TIMEOUT+4)
//  CTRL_HDR     4'b1000  control word bits [15:12] (write=1, ctrl reg addr)
//  CTRL_TAIL    10'h010  control word bits [9:0] (mode/pm/coding/ref/seq fields)
//  PRIO_EN      1        1: PRIO_CH interleaved every other slot; 0: plain round robin
//  PRIO_CH      0        priority channel index (0..3)
//  TIMEOUT      64       max clk cycles from spi_start to spi_done
// PORTS
//  clk          in   1   system clock (all logic on rising edge)
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   1: run schedule; 0: finish current frame, then idle
//  err_clr      in   1   1-cycle pulse, clears sticky error flags
//  spi_start    out  1   1-cycle pulse, starts one 16-bit SPI frame
//  spi_tx       out  16  control word; stable from spi_start until spi_done
//  spi_done     in   1   1-cycle pulse, frame finished, spi_rx valid this cycle
//  spi_rx       in   16  received frame: [14:13]=chID, [12:0]=result
//  vout,temp    out  13  latest result ch0, ch1
//  vin,iout     out  13  latest result ch2, ch3
//  upd          out  4   one-hot 1-cycle pulse, bit n = result n updated this cycle
//  busy         out  1   1 while a frame is outstanding (START..UPDATE)
//  err_chid     out  1   sticky: returned chID != expected channel
//  err_timeout  out  1   sticky: spi_done not seen within TIMEOUT cycles
// BEHAVIOUR
//  Reset: all outputs 0, schedule restarts at slot 0, prev_valid=0, period counter=0.
//  FSM: IDLE -> WAIT_TICK -> START -> WAIT_DONE -> UPDATE -> WAIT_TICK.
//   IDLE: en=1 -> WAIT_TICK, period counter cleared.
//   WAIT_TICK: period counter counts 0..PERIOD-1, wraps; at count==0 -> START; en=0 -> IDLE.
//   START: spi_start=1 for exactly 1 cycle, spi_tx={CTRL_HDR,cur_ch,CTRL_TAIL}; -> WAIT_DONE.
//   WAIT_DONE: spi_done=1 -> UPDATE (spi_rx captured); watchdog reaches TIMEOUT -> set
//     err_timeout, prev_valid=0, -> WAIT_TICK (slot still advances).
//   UPDATE (1 cycle): process capture, advance slot, -> WAIT_TICK (or IDLE if en=0).
//  Pipeline: a frame returns the conversion addressed in the PREVIOUS frame. expected=prev_ch.
//   prev_valid=0 (first frame after reset/IDLE/timeout): result discarded, no upd, no error.
//   prev_valid=1 and spi_rx[14:13]==prev_ch: result reg[prev_ch]<=spi_rx[12:0], upd[prev_ch]=1.
//   prev_valid=1 and mismatch: result discarded, err_chid<=1, no upd.
//   Then prev_ch<=cur_ch, prev_valid<=1.
//  upd asserts in the cycle after UPDATE (registered with result); results hold otherwise.
//  Schedule: PRIO_EN=0 -> 0,1,2,3,0,...; PRIO_EN=1 -> PRIO_CH alternates with round-robin over
//   other 3 channels, e.g. PRIO_CH=0: 0,1,0,2,0,3,0,1,... RR pointer wraps, skips PRIO_CH.
//  spi_done outside WAIT_DONE ignored (no state change, no error).
//  err_clr same cycle as new error: error wins (flag stays 1). Errors never block scheduling.
//  en deasserted in WAIT_DONE: frame completes normally, then IDLE; prev_valid cleared in IDLE.
//  Async reset mid-frame: immediate return to IDLE state, outputs 0; late spi_done ignored.
//  Frame rate = clk/PERIOD; pulse spacing independent of SPI latency (counter free-runs).
// TESTING
//  1 Reset, en=1, PRIO_EN=0, model echoes chID of previous tx -> tx ch seq 0,1,2,3,0; first
//    frame no upd; then upd=0001,0010,0100,1000; spi_start spacing exactly PERIOD cycles.
//  2 PRIO_EN=1,PRIO_CH=0 -> tx channel seq 0,1,0,2,0,3,0,1 over 8 frames.
//  3 Model returns chID=2 when 1 expected, data 13'h0ABC -> err_chid=1, no upd, vout..iout
//    unchanged; err_clr pulse -> err_chid=0.
//  4 Model withholds spi_done -> err_timeout=1 after TIMEOUT cycles; next frame's result
//    discarded (no upd), following frame updates normally.
//  5 Drop en during WAIT_DONE -> frame completes, upd pulses once, FSM idles, no further
//    spi_start; re-enable -> first frame discarded again.
//  6 Assert rst_n=0 mid WAIT_DONE -> all outputs 0 immediately; stray spi_done ignored.

Source files
------------

// File: rtl/adc_channel_sequencer_if.sv
// SPI shift-engine handshake between the ADC channel sequencer and the SPI engine.
//   spi_start : 1-cycle pulse, start one 16-bit frame   (sequencer -> engine)
//   spi_tx    : control word, held until spi_done        (sequencer -> engine)
//   spi_done  : 1-cycle pulse, frame finished            (engine -> sequencer)
//   spi_rx    : received frame, valid with spi_done      (engine -> sequencer)
interface adc_channel_sequencer_if;
  logic        spi_start;
  logic [15:0] spi_tx;
  logic        spi_done;
  logic [15:0] spi_rx;

  modport master (
    output spi_start,
    output spi_tx,
    input  spi_done,
    input  spi_rx
  );

  modport slave (
    input  spi_start,
    input  spi_tx,
    output spi_done,
    output spi_rx
  );
endinterface

// File: rtl/adc_channel_sequencer.sv
// AD7324 conversion scheduler for 4 channels (0=Vout, 1=Temp, 2=Vin, 3=Iout).
// Starts one SPI frame every PERIOD clocks, builds the control word for the
// scheduled channel, and routes each returned result (which belongs to the
// channel addressed in the previous frame) into its result register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : run schedule; when low, the frame in flight completes, then idle
//   err_clr      : pulse, clears sticky error flags (a new error in the same cycle wins)
//   spi          : SPI engine handshake (master side)
//   vout..iout   : latest 13-bit result per channel
//   upd          : one-hot pulse, result n updated this cycle
//   busy         : frame outstanding (START..UPDATE)
//   err_chid     : sticky, returned channel ID did not match the expected one
//   err_timeout  : sticky, spi_done not seen within TIMEOUT cycles of spi_start
module adc_channel_sequencer #(
  parameter int unsigned PERIOD    = 200,
  parameter logic [3:0]  CTRL_HDR  = 4'b1000,
  parameter logic [9:0]  CTRL_TAIL = 10'h010,
  parameter bit          PRIO_EN   = 1'b1,
  parameter int unsigned PRIO_CH   = 0,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    err_clr,
  adc_channel_sequencer_if.master spi,
  output logic [12:0]             vout,
  output logic [12:0]             temp,
  output logic [12:0]             vin,
  output logic [12:0]             iout,
  output logic [3:0]              upd,
  output logic                    busy,
  output logic                    err_chid,
  output logic                    err_timeout
);

  localparam int unsigned   CW         = $clog2(PERIOD);
  localparam int unsigned   WW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TICK_LAST  = CW'(PERIOD - 1);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT);
  localparam logic [1:0]    PRIO       = 2'(PRIO_CH);
  // Round-robin pointer must never start on the priority channel.
  localparam logic [1:0]    RR_FIRST   = (PRIO_EN && PRIO == 2'd0) ? 2'd1 : 2'd0;

  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DONE, UPDATE} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [WW-1:0] wdog;
  logic [1:0]    rr;
  logic          prio_turn;
  logic [1:0]    prev_ch;
  logic          prev_valid;
  logic [14:0]   rx_q;
  logic [12:0]   res [4];

  logic [1:0]    cur_ch;
  logic [1:0]    rr_next;
  logic [1:0]    rr_adv;
  logic          prio_turn_adv;

  assign vout = res[0];
  assign temp = res[1];
  assign vin  = res[2];
  assign iout = res[3];

  // Slot schedule: with PRIO_EN the priority channel takes every other slot and
  // the RR pointer only moves after its own slot, skipping the priority channel.
  always_comb begin
    cur_ch  = (PRIO_EN && prio_turn) ? PRIO : rr;
    rr_next = rr + 2'd1;
    if (PRIO_EN && rr_next == PRIO) rr_next = rr_next + 2'd1;
    prio_turn_adv = PRIO_EN ? ~prio_turn : prio_turn;
    rr_adv        = (PRIO_EN && prio_turn) ? rr : rr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      wdog          <= '0;
      rr            <= RR_FIRST;
      prio_turn     <= 1'b1;
      prev_ch       <= '0;
      prev_valid    <= 1'b0;
      rx_q          <= '0;
      for (int unsigned i = 0; i < 4; i++) res[i] <= '0;
      upd           <= '0;
      busy          <= 1'b0;
      err_chid      <= 1'b0;
      err_timeout   <= 1'b0;
      spi.spi_start <= 1'b0;
      spi.spi_tx    <= '0;
    end else begin
      spi.spi_start <= 1'b0;
      upd           <= '0;
      // Clear first so a same-cycle error assignment below takes precedence.
      if (err_clr) begin
        err_chid    <= 1'b0;
        err_timeout <= 1'b0;
      end

      // Frame timebase free-runs while active so start spacing ignores SPI latency.
      if (state == IDLE) tick_cnt <= '0;
      else               tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          prev_valid <= 1'b0;
          if (en) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick_cnt == '0) begin
            state         <= START;
            spi.spi_start <= 1'b1;
            spi.spi_tx    <= {CTRL_HDR, cur_ch, CTRL_TAIL};
            busy          <= 1'b1;
          end
        end
        START: begin
          state <= WAIT_DONE;
          wdog  <= WW'(1);
        end
        WAIT_DONE: begin
          if (spi.spi_done) begin
            rx_q  <= spi.spi_rx[14:0];
            state <= UPDATE;
          end else if (wdog >= WDOG_LIMIT) begin
            err_timeout <= 1'b1;
            prev_valid  <= 1'b0;
            prio_turn   <= prio_turn_adv;
            rr          <= rr_adv;
            busy        <= 1'b0;
            state       <= WAIT_TICK;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        UPDATE: begin
          if (prev_valid) begin
            if (rx_q[14:13] == prev_ch) begin
              res[prev_ch] <= rx_q[12:0];
              upd[prev_ch] <= 1'b1;
            end else begin
              err_chid <= 1'b1;
            end
          end
          prev_ch    <= cur_ch;
          prev_valid <= 1'b1;
          prio_turn  <= prio_turn_adv;
          rr         <= rr_adv;
          busy       <= 1'b0;
          state      <= en ? WAIT_TICK : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
